alu_operand_seq: RTL and testbench

- Upstream operand-entry stage for the 4-bit ALU.
- Takes one shared 4-bit switch bank and two raw push buttons, then captures operand A, operand B and the 3-bit opcode in sequence.
- Holds all three stable on registered outputs and pulses op_valid once a full operation has been entered.
- Drives the ALU's a, b and ctrl inputs directly, so the ALU never sees switch bounce or partial entry.

---
 rtl/alu_operand_seq_pkg.sv | 21 ++
 rtl/alu_operand_seq_btn_debounce.sv | 51 +++++
 rtl/alu_operand_seq.sv | 115 +++++++++++
 tb/tb_alu_operand_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_seq_pkg.sv
// Shared FSM state encodings and ALU opcode constants for the operand-entry stage.
// Imported by the entry FSM and the ALU so both agree on the opcode map.
package alu_operand_seq_pkg;

   typedef enum logic [1:0] {
      ST_A   = 2'd0,
      ST_B   = 2'd1,
      ST_OP  = 2'd2,
      ST_RUN = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/alu_operand_seq_btn_debounce.sv
// Raw button conditioner: 2-flop sync, stability-count debounce, rising-edge press pulse.
// Press pulse lands 2 + DEB_CYCLES + 1 cycles after a clean edge; no backpressure.
module btn_debounce #(
   parameter logic [15:0] DEB_CYCLES = 16'd50000,
   parameter int          CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 16'd1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
         // Any return to the accepted level restarts the stability window.
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == DEB_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;

endmodule

// File: rtl/alu_operand_seq.sv
// Operand-entry sequencer: captures A, B and opcode from one switch bank on debounced presses.
// Outputs update the cycle after a press; op_valid is a single registered pulse; no backpressure.
module alu_operand_seq
   import alu_operand_seq_pkg::*;
#(
   parameter logic [15:0] DEB_CYCLES = 16'd50000,
   parameter int          CNT_W      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   input  logic       btn_next,
   input  logic       btn_clr,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [2:0] ctrl,
   output logic       op_valid,
   output logic [1:0] state
);

   logic       w_next_press;
   logic       w_clr_press;
   logic       w_unused_next_level;
   logic       w_unused_clr_level;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_a;
   logic [3:0] r_b;
   logic [2:0] r_ctrl;
   logic       r_op_valid;
   logic [3:0] w_a_nxt;
   logic [3:0] w_b_nxt;
   logic [2:0] w_ctrl_nxt;
   logic       w_op_valid_nxt;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_next_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_next),
      .o_level (w_unused_next_level),
      .o_press (w_next_press)
   );

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_clr_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_clr),
      .o_level (w_unused_clr_level),
      .o_press (w_clr_press)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_A;
         r_a        <= 4'h0;
         r_b        <= 4'h0;
         r_ctrl     <= 3'b000;
         r_op_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_op_valid <= w_op_valid_nxt;
      end
   end

   // Clear takes priority so a simultaneous next press is simply dropped.
   always_comb begin
      w_state_nxt    = r_state;
      w_a_nxt        = r_a;
      w_b_nxt        = r_b;
      w_ctrl_nxt     = r_ctrl;
      w_op_valid_nxt = 1'b0;
      if (w_clr_press) begin
         w_state_nxt = ST_A;
         w_a_nxt     = 4'h0;
         w_b_nxt     = 4'h0;
         w_ctrl_nxt  = 3'b000;
      end else if (w_next_press) begin
         case (r_state)
            ST_A: begin
               w_a_nxt     = sw;
               w_state_nxt = ST_B;
            end
            ST_B: begin
               w_b_nxt     = sw;
               w_state_nxt = ST_OP;
            end
            ST_OP: begin
               w_ctrl_nxt     = sw[2:0];
               w_state_nxt    = ST_RUN;
               w_op_valid_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = ST_A;
            end
         endcase
      end
   end

   assign a        = r_a;
   assign b        = r_b;
   assign ctrl     = r_ctrl;
   assign op_valid = r_op_valid;
   assign state    = r_state;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a 4-cycle debounce window.
module tb_alu_operand_seq;

   localparam logic [1:0] SA   = 2'd0;
   localparam logic [1:0] SB   = 2'd1;
   localparam logic [1:0] SOP  = 2'd2;
   localparam logic [1:0] SRUN = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] sw;
   logic       btn_next;
   logic       btn_clr;
   logic [3:0] a;
   logic [3:0] b;
   logic [2:0] ctrl;
   logic       op_valid;
   logic [1:0] state;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   vld_cnt;
   int   vld_consec;
   logic prev_vld = 1'b0;

   alu_operand_seq #(
      .DEB_CYCLES (16'd4),
      .CNT_W      (16)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw       (sw),
      .btn_next (btn_next),
      .btn_clr  (btn_clr),
      .a        (a),
      .b        (b),
      .ctrl     (ctrl),
      .op_valid (op_valid),
      .state    (state)
   );

   always #5 clk = ~clk;

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (op_valid === 1'b1) vld_cnt++;
         if (op_valid === 1'b1 && prev_vld === 1'b1) vld_consec++;
         prev_vld = op_valid;
      end
   endtask

   task automatic press_next(input logic [3:0] v);
      @(negedge clk);
      sw       = v;
      btn_next = 1'b1;
      run_cycles(12);
      @(negedge clk);
      btn_next = 1'b0;
      run_cycles(10);
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      sw       = 4'h0;
      btn_next = 1'b0;
      btn_clr  = 1'b0;
      run_cycles(3);
      @(negedge clk);
      rst_n = 1'b1;
      run_cycles(1);
      n_checks++; if (a !== 4'h0) begin n_fail++; $display("FAIL reset_a: got %h want %h", a, 4'h0); end
      n_checks++; if (b !== 4'h0) begin n_fail++; $display("FAIL reset_b: got %h want %h", b, 4'h0); end
      n_checks++; if (ctrl !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 3'b000); end
      n_checks++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid: got %b want 0", op_valid); end
      n_checks++; if (state !== SA) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, SA); end
   endtask

   task automatic test_basic_sequence;
      vld_cnt    = 0;
      vld_consec = 0;
      press_next(4'h5);
      n_checks++; if (state !== SB) begin n_fail++; $display("FAIL basic_state_b: got %0d want %0d", state, SB); end
      press_next(4'h3);
      press_next(4'h0);
      n_checks++; if (a !== 4'h5) begin n_fail++; $display("FAIL basic_a: got %h want %h", a, 4'h5); end
      n_checks++; if (b !== 4'h3) begin n_fail++; $display("FAIL basic_b: got %h want %h", b, 4'h3); end
      n_checks++; if (ctrl !== 3'b000) begin n_fail++; $display("FAIL basic_ctrl: got %b want %b", ctrl, 3'b000); end
      n_checks++; if (state !== SRUN) begin n_fail++; $display("FAIL basic_state: got %0d want %0d", state, SRUN); end
      n_checks++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL basic_op_valid_cycles: got %0d want 1", vld_cnt); end
      n_checks++; if (vld_consec !== 0) begin n_fail++; $display("FAIL basic_op_valid_consec: got %0d want 0", vld_consec); end
   endtask

   task automatic test_glitch;
      @(negedge clk);
      sw       = 4'hA;
      btn_next = 1'b1;
      run_cycles(2);
      @(negedge clk);
      btn_next = 1'b0;
      run_cycles(12);
      n_checks++; if (state !== SRUN) begin n_fail++; $display("FAIL glitch_state: got %0d want %0d", state, SRUN); end
      n_checks++; if (a !== 4'h5) begin n_fail++; $display("FAIL glitch_a: got %h want %h", a, 4'h5); end
      n_checks++; if (b !== 4'h3) begin n_fail++; $display("FAIL glitch_b: got %h want %h", b, 4'h3); end
   endtask

   task automatic test_press_latency;
      int first  = 0;
      int npress = 0;
      @(negedge clk);
      sw       = 4'hC;
      btn_next = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (u_dut.u_next_deb.o_press === 1'b1) begin
            npress++;
            if (first == 0) first = k;
         end
      end
      @(negedge clk);
      btn_next = 1'b0;
      run_cycles(10);
      n_checks++; if (first !== 7) begin n_fail++; $display("FAIL latency_press_cycle: got %0d want 7", first); end
      n_checks++; if (npress !== 1) begin n_fail++; $display("FAIL held_press_count: got %0d want 1", npress); end
      n_checks++; if (state !== SA) begin n_fail++; $display("FAIL held_state: got %0d want %0d", state, SA); end
      n_checks++; if (a !== 4'h5) begin n_fail++; $display("FAIL run_exit_a_held: got %h want %h", a, 4'h5); end
   endtask

   task automatic test_opcode_and_run;
      vld_cnt    = 0;
      vld_consec = 0;
      press_next(4'h1);
      press_next(4'h4);
      press_next(4'hE);
      n_checks++; if (ctrl !== 3'b110) begin n_fail++; $display("FAIL opcode_bit3_dropped: got %b want %b", ctrl, 3'b110); end
      n_checks++; if (state !== SRUN) begin n_fail++; $display("FAIL opcode_state: got %0d want %0d", state, SRUN); end
      n_checks++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL opcode_op_valid_cycles: got %0d want 1", vld_cnt); end
      press_next(4'hF);
      n_checks++; if (state !== SA) begin n_fail++; $display("FAIL run_exit_state: got %0d want %0d", state, SA); end
      n_checks++; if (a !== 4'h1) begin n_fail++; $display("FAIL run_exit_a: got %h want %h", a, 4'h1); end
      n_checks++; if (b !== 4'h4) begin n_fail++; $display("FAIL run_exit_b: got %h want %h", b, 4'h4); end
      n_checks++; if (ctrl !== 3'b110) begin n_fail++; $display("FAIL run_exit_ctrl: got %b want %b", ctrl, 3'b110); end
      press_next(4'h9);
      n_checks++; if (a !== 4'h9) begin n_fail++; $display("FAIL overwrite_a: got %h want %h", a, 4'h9); end
      n_checks++; if (b !== 4'h4) begin n_fail++; $display("FAIL overwrite_b_kept: got %h want %h", b, 4'h4); end
      n_checks++; if (ctrl !== 3'b110) begin n_fail++; $display("FAIL overwrite_ctrl_kept: got %b want %b", ctrl, 3'b110); end
   endtask

   task automatic test_clear_and_next;
      press_next(4'h2);
      n_checks++; if (state !== SOP) begin n_fail++; $display("FAIL clr_pre_state: got %0d want %0d", state, SOP); end
      n_checks++; if (b !== 4'h2) begin n_fail++; $display("FAIL clr_pre_b: got %h want %h", b, 4'h2); end
      vld_cnt = 0;
      @(negedge clk);
      sw       = 4'h7;
      btn_next = 1'b1;
      btn_clr  = 1'b1;
      run_cycles(15);
      @(negedge clk);
      btn_next = 1'b0;
      btn_clr  = 1'b0;
      run_cycles(10);
      n_checks++; if (a !== 4'h0) begin n_fail++; $display("FAIL clr_a: got %h want %h", a, 4'h0); end
      n_checks++; if (b !== 4'h0) begin n_fail++; $display("FAIL clr_b: got %h want %h", b, 4'h0); end
      n_checks++; if (ctrl !== 3'b000) begin n_fail++; $display("FAIL clr_ctrl: got %b want %b", ctrl, 3'b000); end
      n_checks++; if (state !== SA) begin n_fail++; $display("FAIL clr_state: got %0d want %0d", state, SA); end
      n_checks++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL clr_op_valid: got %0d cycles want 0", vld_cnt); end
   endtask

   task automatic test_reset_mid_debounce;
      int first_press = 0;
      int first_b     = 0;
      press_next(4'h8);
      n_checks++; if (state !== SB) begin n_fail++; $display("FAIL rstmid_pre_state: got %0d want %0d", state, SB); end
      @(negedge clk);
      sw       = 4'hA;
      btn_next = 1'b1;
      run_cycles(4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (a !== 4'h0) begin n_fail++; $display("FAIL rstmid_a: got %h want %h", a, 4'h0); end
      n_checks++; if (state !== SA) begin n_fail++; $display("FAIL rstmid_state: got %0d want %0d", state, SA); end
      run_cycles(2);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (u_dut.u_next_deb.o_press === 1'b1 && first_press == 0) first_press = k;
         if (state === SB && first_b == 0) first_b = k;
      end
      n_checks++; if (first_press !== 7) begin n_fail++; $display("FAIL rstmid_press_cycle: got %0d want 7", first_press); end
      n_checks++; if (first_b !== 8) begin n_fail++; $display("FAIL rstmid_advance_cycle: got %0d want 8", first_b); end
      n_checks++; if (a !== 4'hA) begin n_fail++; $display("FAIL rstmid_a_captured: got %h want %h", a, 4'hA); end
      @(negedge clk);
      btn_next = 1'b0;
      run_cycles(10);
   endtask

   initial begin
      test_reset;
      test_basic_sequence;
      test_glitch;
      test_press_latency;
      test_opcode_and_run;
      test_clear_and_next;
      test_reset_mid_debounce;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
